// File: rtl/mem_arbiter_if.sv
// Bundle of requester, memory and status signals shared by the arbiter and its environment.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
);
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_gnt;
   logic                  if_rvalid;
   logic [DATA_WIDTH-1:0] if_rdata;
   logic                  dm_rd;
   logic                  dm_wr;
   logic [ADDR_WIDTH-1:0] dm_addr;
   logic [DATA_WIDTH-1:0] dm_w_data;
   logic                  dm_gnt;
   logic                  dm_rvalid;
   logic [DATA_WIDTH-1:0] dm_rdata;
   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_WIDTH:0]   mem_addr;
   logic [DATA_WIDTH-1:0] mem_w_data;
   logic [DATA_WIDTH-1:0] mem_r_data;
   logic                  proto_err;

   modport master (
      output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_w_data, mem_r_data,
      input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_en, mem_we, mem_addr, mem_w_data, proto_err
   );

   modport slave (
      input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_w_data, mem_r_data,
      output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_en, mem_we, mem_addr, mem_w_data, proto_err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch vs data) onto one single-port memory with
// data-first priority, IF starvation override and a 1-cycle read-return owner tag.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int STARVE_MAX = 3
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);
   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_t;

   owner_t                owner_q, owner_d;
   logic [CW-1:0]         starve_q, starve_d;
   logic                  proto_q, proto_d;
   logic                  dm_req, force_if;
   logic                  if_gnt, dm_gnt;
   logic                  mem_en, mem_we;
   logic [ADDR_WIDTH:0]   mem_addr;
   logic [DATA_WIDTH-1:0] mem_w_data;
   logic                  if_rvalid, dm_rvalid;

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q  <= OWN_NONE;
         starve_q <= '0;
         proto_q  <= 1'b0;
      end else begin
         owner_q  <= owner_d;
         starve_q <= starve_d;
         proto_q  <= proto_d;
      end
   end

   always_comb begin
      owner_d    = OWN_NONE;
      starve_d   = '0;
      proto_d    = proto_q | (bus.dm_rd & bus.dm_wr);
      if_gnt     = 1'b0;
      dm_gnt     = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_w_data = '0;
      dm_req     = bus.dm_rd | bus.dm_wr;
      force_if   = bus.if_req && (starve_q == STARVE_LIM);

      if (!rst) begin
         // Data wins by default; a saturated starvation count hands the cycle to IF.
         if (bus.if_req && (force_if || !dm_req)) begin
            if_gnt   = 1'b1;
            mem_en   = 1'b1;
            mem_addr = {1'b0, bus.if_addr};
            owner_d  = OWN_IF;
         end else if (dm_req) begin
            dm_gnt     = 1'b1;
            mem_en     = 1'b1;
            mem_we     = bus.dm_wr;
            mem_addr   = {1'b1, bus.dm_addr};
            mem_w_data = bus.dm_w_data;
            owner_d    = bus.dm_wr ? OWN_NONE : OWN_DM;
         end

         if (bus.if_req && !if_gnt) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
         end
      end
   end

   // Gating with rst drops a read whose data would return during reset.
   assign if_rvalid = !rst && (owner_q == OWN_IF);
   assign dm_rvalid = !rst && (owner_q == OWN_DM);

   assign bus.if_gnt     = if_gnt;
   assign bus.dm_gnt     = dm_gnt;
   assign bus.mem_en     = mem_en;
   assign bus.mem_we     = mem_we;
   assign bus.mem_addr   = mem_addr;
   assign bus.mem_w_data = mem_w_data;
   assign bus.if_rvalid  = if_rvalid;
   assign bus.dm_rvalid  = dm_rvalid;
   assign bus.if_rdata   = if_rvalid ? bus.mem_r_data : '0;
   assign bus.dm_rdata   = dm_rvalid ? bus.mem_r_data : '0;
   assign bus.proto_err  = proto_q & ~rst;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, starvation sequence and random traffic
// checked against a cycle-level reference model.
module tb_mem_arbiter;
   localparam int AW   = 8;
   localparam int DW   = 16;
   localparam int SMAX = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_MAX(SMAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic        rst;
      logic        if_req;
      logic [7:0]  if_addr;
      logic        dm_rd;
      logic        dm_wr;
      logic [7:0]  dm_addr;
      logic [15:0] dm_w_data;
      logic [15:0] mem_r_data;
   } in_t;

   typedef struct packed {
      logic        if_gnt;
      logic        dm_gnt;
      logic        mem_en;
      logic        mem_we;
      logic [8:0]  mem_addr;
      logic [15:0] mem_w_data;
      logic        if_rvalid;
      logic [15:0] if_rdata;
      logic        dm_rvalid;
      logic [15:0] dm_rdata;
      logic        proto_err;
   } out_t;

   typedef struct {
      in_t   i;
      out_t  o;
      string tag;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: IF denial streak, which port has read data due next cycle, sticky error.
   int m_starve = 0;
   int m_pend   = 0;   // 0 none, 1 IF, 2 DM
   bit m_proto  = 1'b0;

   function automatic in_t mk_in(bit r, bit ir, logic [7:0] ia, bit rd, bit wr,
                                 logic [7:0] da, logic [15:0] wd, logic [15:0] md);
      in_t x;
      x = '{r, ir, ia, rd, wr, da, wd, md};
      return x;
   endfunction

   function automatic out_t mk_out(bit ig, bit dg, bit en, bit we, logic [8:0] a,
                                   logic [15:0] wd, bit iv, logic [15:0] id,
                                   bit dv, logic [15:0] dd, bit pe);
      out_t o;
      o = '{ig, dg, en, we, a, wd, iv, id, dv, dd, pe};
      return o;
   endfunction

   // Returns {if_wins, dm_wins} for the current model state.
   function automatic logic [1:0] winner(in_t x);
      bit data_req, if_w, dm_w;
      data_req = x.dm_rd || x.dm_wr;
      if_w = !x.rst && x.if_req && (m_starve == SMAX || !data_req);
      dm_w = !x.rst && data_req && !if_w;
      return {if_w, dm_w};
   endfunction

   function automatic out_t model_out(in_t x);
      out_t o;
      logic [1:0] w;
      o = '0;
      w = winner(x);
      if (!x.rst) begin
         if (w[1]) begin
            o.if_gnt = 1'b1; o.mem_en = 1'b1; o.mem_addr = {1'b0, x.if_addr};
         end else if (w[0]) begin
            o.dm_gnt = 1'b1; o.mem_en = 1'b1; o.mem_we = x.dm_wr;
            o.mem_addr = {1'b1, x.dm_addr}; o.mem_w_data = x.dm_w_data;
         end
         if (m_pend == 1) begin o.if_rvalid = 1'b1; o.if_rdata = x.mem_r_data; end
         if (m_pend == 2) begin o.dm_rvalid = 1'b1; o.dm_rdata = x.mem_r_data; end
         o.proto_err = m_proto;
      end
      return o;
   endfunction

   task automatic model_step(in_t x);
      logic [1:0] w;
      w = winner(x);
      if (x.rst) begin
         m_starve = 0; m_pend = 0; m_proto = 1'b0;
      end else begin
         m_starve = (x.if_req && !w[1]) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
         m_pend   = w[1] ? 1 : ((w[0] && !x.dm_wr) ? 2 : 0);
         m_proto  = m_proto || (x.dm_rd && x.dm_wr);
      end
   endtask

   task automatic chk(string tag, string f, logic [31:0] act, logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s %s: got %h, want %h", tag, f, act, exp);
      end
   endtask

   task automatic compare(out_t e, string tag);
      n_vec++;
      chk(tag, "if_gnt",     32'(bus.if_gnt),     32'(e.if_gnt));
      chk(tag, "dm_gnt",     32'(bus.dm_gnt),     32'(e.dm_gnt));
      chk(tag, "mem_en",     32'(bus.mem_en),     32'(e.mem_en));
      chk(tag, "mem_we",     32'(bus.mem_we),     32'(e.mem_we));
      chk(tag, "mem_addr",   32'(bus.mem_addr),   32'(e.mem_addr));
      chk(tag, "mem_w_data", 32'(bus.mem_w_data), 32'(e.mem_w_data));
      chk(tag, "if_rvalid",  32'(bus.if_rvalid),  32'(e.if_rvalid));
      chk(tag, "if_rdata",   32'(bus.if_rdata),   32'(e.if_rdata));
      chk(tag, "dm_rvalid",  32'(bus.dm_rvalid),  32'(e.dm_rvalid));
      chk(tag, "dm_rdata",   32'(bus.dm_rdata),   32'(e.dm_rdata));
      chk(tag, "proto_err",  32'(bus.proto_err),  32'(e.proto_err));
      $display("vec %0d %s: gnt if=%b dm=%b addr=%h rv if=%b dm=%b perr=%b", n_vec, tag,
               bus.if_gnt, bus.dm_gnt, bus.mem_addr, bus.if_rvalid, bus.dm_rvalid, bus.proto_err);
   endtask

   task automatic run(in_t x, out_t e, bit use_model, bit check, string tag);
      out_t ee;
      @(posedge clk);
      #2;
      rst            = x.rst;
      bus.if_req     = x.if_req;
      bus.if_addr    = x.if_addr;
      bus.dm_rd      = x.dm_rd;
      bus.dm_wr      = x.dm_wr;
      bus.dm_addr    = x.dm_addr;
      bus.dm_w_data  = x.dm_w_data;
      bus.mem_r_data = x.mem_r_data;
      #3;
      ee = use_model ? model_out(x) : e;
      if (check) compare(ee, tag);
      model_step(x);
   endtask

   vec_t tbl[$];

   initial begin
      in_t  x;
      out_t e;
      out_t zero_o;
      zero_o = '0;

      tbl.push_back(vec_t'{mk_in(1,1,8'h05,1,0,8'h00,16'h0000,16'h0000), mk_out(0,0,0,0,9'h000,16'h0000,0,16'h0000,0,16'h0000,0), "rst_hold"});
      tbl.push_back(vec_t'{mk_in(0,1,8'h05,0,0,8'h00,16'h0000,16'h0000), mk_out(1,0,1,0,9'h005,16'h0000,0,16'h0000,0,16'h0000,0), "if_alone"});
      tbl.push_back(vec_t'{mk_in(0,0,8'h00,0,0,8'h00,16'h0000,16'h1234), mk_out(0,0,0,0,9'h000,16'h0000,1,16'h1234,0,16'h0000,0), "if_rvalid"});
      tbl.push_back(vec_t'{mk_in(0,1,8'h22,0,1,8'h10,16'hBEEF,16'h0000), mk_out(0,1,1,1,9'h110,16'hBEEF,0,16'h0000,0,16'h0000,0), "dm_wr_wins"});
      tbl.push_back(vec_t'{mk_in(0,0,8'h00,0,0,8'h00,16'h0000,16'h5555), mk_out(0,0,0,0,9'h000,16'h0000,0,16'h0000,0,16'h0000,0), "wr_no_rvalid"});
      tbl.push_back(vec_t'{mk_in(0,0,8'h00,1,1,8'h33,16'h0A0A,16'h0000), mk_out(0,1,1,1,9'h133,16'h0A0A,0,16'h0000,0,16'h0000,0), "rd_wr_both"});
      tbl.push_back(vec_t'{mk_in(0,0,8'h00,0,0,8'h00,16'h0000,16'h7777), mk_out(0,0,0,0,9'h000,16'h0000,0,16'h0000,0,16'h0000,1), "proto_sticky"});
      tbl.push_back(vec_t'{mk_in(0,1,8'h40,0,0,8'h00,16'h0000,16'h0000), mk_out(1,0,1,0,9'h040,16'h0000,0,16'h0000,0,16'h0000,1), "alt_if0"});
      tbl.push_back(vec_t'{mk_in(0,0,8'h00,1,0,8'h41,16'h0000,16'hAAAA), mk_out(0,1,1,0,9'h141,16'h0000,1,16'hAAAA,0,16'h0000,1), "alt_dm0"});
      tbl.push_back(vec_t'{mk_in(0,1,8'h42,0,0,8'h00,16'h0000,16'hBBBB), mk_out(1,0,1,0,9'h042,16'h0000,0,16'h0000,1,16'hBBBB,1), "alt_if1"});
      tbl.push_back(vec_t'{mk_in(0,0,8'h00,1,0,8'h43,16'h0000,16'hCCCC), mk_out(0,1,1,0,9'h143,16'h0000,1,16'hCCCC,0,16'h0000,1), "alt_dm1"});
      tbl.push_back(vec_t'{mk_in(1,0,8'h00,0,0,8'h00,16'h0000,16'hDDDD), mk_out(0,0,0,0,9'h000,16'h0000,0,16'h0000,0,16'h0000,0), "rst_after_rd"});
      tbl.push_back(vec_t'{mk_in(0,0,8'h00,0,0,8'h00,16'h0000,16'hEEEE), mk_out(0,0,0,0,9'h000,16'h0000,0,16'h0000,0,16'h0000,0), "post_rst"});

      run(mk_in(1,0,8'h00,0,0,8'h00,16'h0000,16'h0000), zero_o, 1'b0, 1'b0, "init");
      run(mk_in(1,0,8'h00,0,0,8'h00,16'h0000,16'h0000), zero_o, 1'b0, 1'b0, "init");

      foreach (tbl[k]) run(tbl[k].i, tbl[k].o, 1'b0, 1'b1, tbl[k].tag);

      // IF and DM reads held together: three data grants, then one forced IF grant, repeating.
      for (int k = 0; k < 8; k++) begin
         x = mk_in(0, 1, 8'h50, 1, 0, 8'h60, 16'h0000, 16'(16'h1000 + k));
         if (k % 4 == 3) e = mk_out(1,0,1,0,9'h050,16'h0000,0,16'h0000,0,16'h0000,0);
         else            e = mk_out(0,1,1,0,9'h160,16'h0000,0,16'h0000,0,16'h0000,0);
         if (k > 0) begin
            if ((k - 1) % 4 == 3) begin e.if_rvalid = 1'b1; e.if_rdata = x.mem_r_data; end
            else                  begin e.dm_rvalid = 1'b1; e.dm_rdata = x.mem_r_data; end
         end
         run(x, e, 1'b0, 1'b1, $sformatf("starve%0d", k));
      end

      for (int k = 0; k < 400; k++) begin
         x = '0;
         x.rst        = (k == 0) || ($urandom_range(0, 39) == 0);
         x.if_req     = ($urandom_range(0, 3) != 0);
         x.if_addr    = 8'($urandom);
         x.dm_rd      = ($urandom_range(0, 9) < 4);
         x.dm_wr      = ($urandom_range(0, 9) < 3);
         x.dm_addr    = 8'($urandom);
         x.dm_w_data  = 16'($urandom);
         x.mem_r_data = 16'($urandom);
         run(x, zero_o, 1'b1, 1'b1, $sformatf("rnd%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, requester address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, consecutive IF denials before IF is forced priority.
REQ-004 SHALL have one clock; reset is synchronous and active-high; ports clk, rst.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 if_req  input  1  fetch read request.
REQ-008 if_addr  input  ADDR_WIDTH  fetch address.
REQ-009 if_gnt  output  1  fetch request accepted this cycle.
REQ-010 if_rvalid  output  1  fetch read data valid.
REQ-011 if_rdata  output  DATA_WIDTH  fetch read data.
REQ-012 dm_rd  input  1  data read request.
REQ-013 dm_wr  input  1  data write request.
REQ-014 dm_addr  input  ADDR_WIDTH  data address.
REQ-015 dm_w_data  input  DATA_WIDTH  write data.
REQ-016 dm_gnt  output  1  data request accepted this cycle.
REQ-017 dm_rvalid  output  1  data read data valid.
REQ-018 dm_rdata  output  DATA_WIDTH  data read data.
REQ-019 mem_en  output  1  shared single-port memory enable.
REQ-020 mem_we  output  1  memory write enable.
REQ-021 mem_addr  output  ADDR_WIDTH+1  memory address; MSB 0 = instruction region, 1 = data region.
REQ-022 mem_w_data  output  DATA_WIDTH  memory write data.
REQ-023 mem_r_data  input  DATA_WIDTH  memory read data, valid one cycle after read enable.
REQ-024 proto_err  output  1  sticky: dm_rd and dm_wr seen together.

Function
REQ-025 Grants, mem_en, mem_we, mem_addr, mem_w_data SHALL be combinational from current requests and registered priority state; at most one grant per cycle.
REQ-026 Default priority: data port wins when dm_rd or dm_wr asserted together with if_req.
REQ-027 Starvation counter (width clog2(STARVE_MAX+1)) SHALL increment each cycle if_req is high and if_gnt low, clear when if_gnt high or if_req low, saturate at STARVE_MAX.
REQ-028 When counter equals STARVE_MAX, IF SHALL win that cycle regardless of data requests; data port gets dm_gnt=0.
REQ-029 IF grant: mem_en=1, mem_we=0, mem_addr={1'b0,if_addr}.
REQ-030 Data grant: mem_en=1, mem_we=dm_wr, mem_addr={1'b1,dm_addr}, mem_w_data=dm_w_data.
REQ-031 No grant: mem_en=0, mem_we=0, mem_addr=0, mem_w_data=0.
REQ-032 dm_rd and dm_wr both high: treat as write, set proto_err, proto_err held until reset.
REQ-033 Read latency SHALL be exactly 1 cycle: registered owner tag (NONE/IF/DM) captured on a read grant; next cycle the tagged port's rvalid=1 and its rdata=mem_r_data.
REQ-034 Writes SHALL produce no rvalid.
REQ-035 Non-owning port's rdata SHALL be 0 and rvalid 0.
REQ-036 Back-to-back grants every cycle SHALL be supported; owner tag updates every cycle (NONE if no read grant).
REQ-037 A denied requester SHALL hold its request and address until granted; arbiter keeps no request queue.

Reset
REQ-038 On rst: starvation counter 0, owner tag NONE, proto_err 0, if_rvalid 0, dm_rvalid 0, rdata outputs 0.
REQ-039 Grants SHALL be forced 0 and mem_en 0 while rst is high.
REQ-040 Reset asserted the cycle after a read grant SHALL suppress that read's rvalid.

Verification
REQ-041 if_req=1, if_addr=0x05 alone, mem_r_data=0x1234 next cycle -> if_gnt=1, mem_addr=0x005; next cycle if_rvalid=1, if_rdata=0x1234.
REQ-042 dm_wr=1, dm_addr=0x10, dm_w_data=0xBEEF with if_req=1 -> dm_gnt=1, mem_we=1, mem_addr=0x110, if_gnt=0, no rvalid next cycle.
REQ-043 if_req and dm_rd held high continuously, STARVE_MAX=3 -> dm_gnt for 3 cycles, if_gnt on 4th, counter back to 0, pattern repeats.
REQ-044 dm_rd=1, dm_wr=1 one cycle -> write performed, proto_err=1 and stays 1 until rst.
REQ-045 Alternating IF read then DM read every cycle -> each rvalid appears exactly one cycle after its grant on the correct port only.
REQ-046 rst pulsed one cycle after a DM read grant -> dm_rvalid stays 0, counter 0, outputs at reset values.
